// File: rtl/ase_pcie_ss_cpl_reorder.sv
// ase_pcie_ss_cpl_reorder
//   Reorder buffer for DMA read completions on the requester side. Read tags are
//   allocated in request order. Completion beats come back out of order and are
//   stored in a {tag, beat} data RAM. Each request's beats are then released to the
//   AFU consumer in the original request order.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; req_beats = beats expected (1..MAX_BEATS)
//   req_tag                    tag assigned to the request (alloc pointer, combinational)
//   cpl_valid/tag/beat/data    completion beat, always accepted
//   out_valid/ready            in-order output handshake
//   out_data/tag/last          output beat, its tag, final-beat flag
//   err                        one-cycle pulse on a dropped (illegal) beat or zero-beat request
//
// Build option
//   ASE_PCIE_SS_CPL_CHECK_EN   when defined, protocol checks drop illegal beats and pulse err.
//                              When undefined, every beat is written and counted, and err is 0.

module ase_pcie_ss_cpl_reorder #(
  parameter  int NUM_TAGS   = 64,
  parameter  int DATA_WIDTH = 512,
  parameter  int MAX_BEATS  = 8,
  localparam int TW         = $clog2(NUM_TAGS),
  localparam int BW         = $clog2(MAX_BEATS),
  localparam int CW         = BW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CW-1:0]         req_beats,
  output logic [TW-1:0]         req_tag,
  input  logic                  cpl_valid,
  input  logic [TW-1:0]         cpl_tag,
  input  logic [BW-1:0]         cpl_beat,
  input  logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TW-1:0]         out_tag,
  output logic                  out_last,
  output logic                  err
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   ram [NUM_TAGS*MAX_BEATS];
  logic [NUM_TAGS-1:0]     busy;
  logic [CW-1:0]           exp_cnt [NUM_TAGS];
  logic [CW-1:0]           rcv_cnt [NUM_TAGS];
  logic [TW-1:0]           alloc_ptr, rel_ptr, start_ptr;
  logic [CW-1:0]           rd_beat;   // beats of rel_ptr already moved to the output register
  logic [CW-1:0]           req_cnt;
  logic [TW+BW-1:0]        rd_addr;
  logic                    req_fire, req_zero, cpl_bad, cpl_ok;
  logic                    last_acc, can_adv, issue_cont, start;

  // ---------------- allocation ----------------
  assign req_ready = !busy[alloc_ptr];
  assign req_tag   = alloc_ptr;
  assign req_fire  = req_valid && req_ready;
  assign req_zero  = (req_beats == '0);
  // A zero-beat request would never complete; it is treated as one beat.
  assign req_cnt   = req_zero ? CW'(1) : req_beats;

  // ---------------- capture checks ----------------
`ifdef ASE_PCIE_SS_CPL_CHECK_EN
  assign cpl_bad = cpl_valid &&
                   (!busy[cpl_tag] ||
                    ({1'b0, cpl_beat} >= exp_cnt[cpl_tag]) ||
                    (rcv_cnt[cpl_tag] == exp_cnt[cpl_tag]));
`else
  assign cpl_bad = 1'b0;
`endif
  assign cpl_ok = cpl_valid && !cpl_bad;

  // ---------------- release control ----------------
  // The output register advances when it is empty or being drained this cycle.
  assign last_acc   = out_valid && out_ready && out_last;
  assign can_adv    = !out_valid || out_ready;
  // When the last beat of the current tag leaves, the next tag can start in the
  // same cycle so that back-to-back complete tags stream without a bubble.
  assign start_ptr  = last_acc ? rel_ptr + 1'b1 : rel_ptr;
  assign issue_cont = (state == STREAM) && (rd_beat != exp_cnt[rel_ptr]) && can_adv;
  assign start      = ((state == IDLE) || last_acc) && busy[start_ptr] &&
                      (rcv_cnt[start_ptr] == exp_cnt[start_ptr]);
  assign rd_addr    = start ? {start_ptr, {BW{1'b0}}} : {rel_ptr, rd_beat[BW-1:0]};

  // Data RAM write port. Reads only target complete tags, and (with checks on) a
  // complete tag never takes another write, so there is no read/write collision.
  always_ff @(posedge clk) begin
    if (cpl_ok) ram[{cpl_tag, cpl_beat}] <= cpl_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= '0;
      alloc_ptr <= '0;
      rel_ptr   <= '0;
      rd_beat   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_last  <= 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) begin
        exp_cnt[t] <= '0;
        rcv_cnt[t] <= '0;
      end
    end else begin
      if (cpl_ok) rcv_cnt[cpl_tag] <= rcv_cnt[cpl_tag] + 1'b1;

      // An allocated tag is never busy, so it cannot collide with the release tag.
      if (req_fire) begin
        busy[alloc_ptr]    <= 1'b1;
        exp_cnt[alloc_ptr] <= req_cnt;
        rcv_cnt[alloc_ptr] <= '0;
        alloc_ptr          <= alloc_ptr + 1'b1;
      end

      if (last_acc) begin
        busy[rel_ptr] <= 1'b0;
        rel_ptr       <= start_ptr;
      end

      if (start) begin
        state     <= STREAM;
        rd_beat   <= CW'(1);
        out_valid <= 1'b1;
        out_data  <= ram[rd_addr];
        out_tag   <= start_ptr;
        out_last  <= (exp_cnt[start_ptr] == CW'(1));
      end else if (issue_cont) begin
        rd_beat   <= rd_beat + 1'b1;
        out_valid <= 1'b1;
        out_data  <= ram[rd_addr];
        out_tag   <= rel_ptr;
        out_last  <= (rd_beat == exp_cnt[rel_ptr] - 1'b1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (last_acc) state <= IDLE;
      end
    end
  end

`ifdef ASE_PCIE_SS_CPL_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= cpl_bad || (req_fire && req_zero);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ase_pcie_ss_cpl_reorder.sv
module tb_ase_pcie_ss_cpl_reorder;
  localparam int NT = 64;
  localparam int DW = 512;
  localparam int MB = 8;
  localparam int TW = 6;
  localparam int BW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_beats = '0;
  logic [TW-1:0] req_tag;
  logic          cpl_valid = 1'b0;
  logic [TW-1:0] cpl_tag = '0;
  logic [BW-1:0] cpl_beat = '0;
  logic [DW-1:0] cpl_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_last;
  logic          err;

  always #5 clk = ~clk;

  ase_pcie_ss_cpl_reorder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_beats(req_beats), .req_tag(req_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_beat(cpl_beat), .cpl_data(cpl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .err(err)
  );

  // Reference model: the output stream is simply every request's beats, in
  // request order, with last set on each request's final beat.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] mdata [NT][MB];
  int            pend[$];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic shuffle_pend();
    for (int i = pend.size() - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = pend[i];
      pend[i] = pend[j];
      pend[j] = t;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    cpl_valid = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_req(input int beats, input int want_tag);
    int n;
    n = (beats == 0) ? 1 : beats;
    req_valid = 1'b1;
    req_beats = CW'(beats);
    chk("req_ready", DW'(req_ready), DW'(1));
    chk("req_tag", DW'(req_tag), DW'(want_tag));
    for (int b = 0; b < n; b++) begin
      mdata[want_tag][b] = rnd_data();
      exp_q.push_back('{TW'(want_tag), mdata[want_tag][b], (b == n - 1)});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_cpl(input int t, input int b);
    cpl_valid = 1'b1;
    cpl_tag   = TW'(t);
    cpl_beat  = BW'(b);
    cpl_data  = mdata[t][b];
    tick();
    cpl_valid = 1'b0;
  endtask

  task automatic drain(input int bound, input bit rnd_ready);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      c++;
    end
    out_ready = 1'b1;
    chk("drain_left", DW'(exp_q.size()), DW'(0));
    tick();
    chk("idle_after_drain", DW'(out_valid), DW'(0));
  endtask

  task automatic wait_valid(input int bound);
    int c;
    c = 0;
    while (!out_valid && c < bound) begin
      tick();
      c++;
    end
    chk("wait_valid", DW'(out_valid), DW'(1));
  endtask

  // Output monitor: handshakes are judged at the falling edge, where inputs and
  // outputs are both settled for the coming rising edge.
  beat_t         mon_e;
  logic          p_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic [TW-1:0] p_tag;
  logic          p_last;

  always @(negedge clk) begin
    if (reset) begin
      p_stall <= 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_valid", DW'(out_valid), DW'(1));
        chk("hold_data", out_data, p_data);
        chk("hold_tag", DW'(out_tag), DW'(p_tag));
        chk("hold_last", DW'(out_last), DW'(p_last));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_tag", DW'(out_tag), DW'(mon_e.tag));
          chk("out_data", out_data, mon_e.data);
          chk("out_last", DW'(out_last), DW'(mon_e.last));
        end
      end
      p_stall <= out_valid && !out_ready;
      p_data  <= out_data;
      p_tag   <= out_tag;
      p_last  <= out_last;
    end
  end

  initial begin
    int order[4];
    int next_tag;

    // ---- reset values ----
    do_reset();
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    chk("rst_req_tag", DW'(req_tag), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_last", DW'(out_last), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_tag", DW'(out_tag), DW'(0));
    out_ready = 1'b1;

    // ---- four 2-beat requests, completions 3,1,0,2 ----
    for (int t = 0; t < 4; t++) do_req(2, t);
    order = '{3, 1, 0, 2};
    for (int i = 0; i < 4; i++) begin
      do_cpl(order[i], 0);
      do_cpl(order[i], 1);
    end
    drain(100, 1'b0);

    // ---- single-beat latency: completion in N -> out_valid in N+2 ----
    do_reset();
    out_ready = 1'b1;
    do_req(1, 0);
    do_cpl(0, 0);
    chk("lat_n1_valid", DW'(out_valid), DW'(0));
    tick();
    chk("lat_n2_valid", DW'(out_valid), DW'(1));
    chk("lat_n2_tag", DW'(out_tag), DW'(0));
    chk("lat_n2_last", DW'(out_last), DW'(1));
    drain(20, 1'b0);

    // ---- full, free and wrap ----
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < NT; t++) do_req(1, t);
    chk("full_ready", DW'(req_ready), DW'(0));
    do_cpl(0, 0);
    tick();
    chk("full_out_valid", DW'(out_valid), DW'(1));
    chk("full_still_busy", DW'(req_ready), DW'(0));
    tick();
    chk("free_ready", DW'(req_ready), DW'(1));
    chk("wrap_tag", DW'(req_tag), DW'(0));
    pend.delete();
    for (int t = 1; t < NT; t++) pend.push_back(t);
    shuffle_pend();
    while (pend.size() != 0) do_cpl(pend.pop_front(), 0);
    drain(400, 1'b1);

    // ---- back-pressure in the middle of an 8-beat tag ----
    do_reset();
    out_ready = 1'b1;
    do_req(8, 0);
    pend.delete();
    for (int b = 0; b < MB; b++) pend.push_back(b);
    shuffle_pend();
    while (pend.size() != 0) do_cpl(0, pend.pop_front());
    wait_valid(10);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_valid", DW'(out_valid), DW'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_valid", DW'(out_valid), DW'(1));
      tick();
    end
    drain(20, 1'b0);

    // ---- completion to an idle tag ----
    do_reset();
    out_ready = 1'b1;
    cpl_valid = 1'b1;
    cpl_tag   = TW'(5);
    cpl_beat  = '0;
    cpl_data  = rnd_data();
    tick();
    cpl_valid = 1'b0;
`ifdef ASE_PCIE_SS_CPL_CHECK_EN
    chk("err_idle_tag", DW'(err), DW'(1));
`else
    chk("err_idle_tag", DW'(err), DW'(0));
`endif
    tick();
    chk("err_one_cycle", DW'(err), DW'(0));
    for (int i = 0; i < 3; i++) begin
      chk("err_no_out", DW'(out_valid), DW'(0));
      tick();
    end
`ifdef ASE_PCIE_SS_CPL_CHECK_EN
    do_req(2, 0);
    mdata[0][2] = rnd_data();
    do_cpl(0, 2);
    chk("err_beat_range", DW'(err), DW'(1));
    do_cpl(0, 0);
    chk("err_clear", DW'(err), DW'(0));
    do_cpl(0, 1);
    cpl_valid = 1'b1;
    cpl_tag   = '0;
    cpl_beat  = BW'(1);
    cpl_data  = rnd_data();
    tick();
    cpl_valid = 1'b0;
    chk("err_after_complete", DW'(err), DW'(1));
    do_req(0, 1);
    chk("err_zero_beats", DW'(err), DW'(1));
    do_cpl(1, 0);
    drain(50, 1'b0);
`endif

    // ---- reset with three tags outstanding ----
    do_reset();
    out_ready = 1'b1;
    do_req(2, 0);
    do_req(2, 1);
    do_req(2, 2);
    do_cpl(1, 0);
    do_cpl(0, 0);
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_ready", DW'(req_ready), DW'(1));
    chk("mid_rst_tag", DW'(req_tag), DW'(0));
    chk("mid_rst_valid", DW'(out_valid), DW'(0));
    reset = 1'b0;
    do_cpl(1, 1);
    repeat (3) tick();
    chk("post_rst_no_out", DW'(out_valid), DW'(0));

    // ---- randomized rounds against the in-order model ----
    do_reset();
    out_ready = 1'b1;
    next_tag = 0;
    for (int r = 0; r < 8; r++) begin
      int nreq;
      nreq = $urandom_range(1, 20);
      pend.delete();
      for (int k = 0; k < nreq; k++) begin
        int bts;
        bts = $urandom_range(1, MB);
        do_req(bts, next_tag);
        for (int b = 0; b < bts; b++) pend.push_back(next_tag * MB + b);
        next_tag = (next_tag + 1) % NT;
      end
      shuffle_pend();
      while (pend.size() != 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) begin
          int p;
          p = pend.pop_front();
          do_cpl(p / MB, p % MB);
        end else begin
          tick();
        end
      end
      drain(2000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ase_pcie_ss_cpl_reorder.md
# ase_pcie_ss_cpl_reorder

Requester-side DMA read completion reorder buffer for the ASE PCIe SS emulation. It allocates read tags in strict request order and captures completion beats that the host emulator returns out of order, split at the request completion boundary. It releases the data to the AFU-side consumer in original request order. It sits between the AFU DMA read engine and the emulated PCIe SS RX stream, and handles the case where the emulator runs with unordered completions.

## Interface
- NUM_TAGS, 64, outstanding read tags; power of 2, at most the emulator's max outstanding DMA read requests
- DATA_WIDTH, 512, completion data beat width in bits
- MAX_BEATS, 8, maximum beats per request (max read request bytes / (DATA_WIDTH/8)); power of 2
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  new read request
- req_ready  out  1  request can be accepted (tag at alloc pointer is free)
- req_beats  in  $clog2(MAX_BEATS)+1  beats expected, 1..MAX_BEATS
- req_tag  out  $clog2(NUM_TAGS)  tag assigned; valid while req_valid && req_ready
- cpl_valid  in  1  completion beat; always accepted (no ready)
- cpl_tag  in  $clog2(NUM_TAGS)  tag of the beat
- cpl_beat  in  $clog2(MAX_BEATS)  beat index within the request
- cpl_data  in  DATA_WIDTH  payload
- out_valid  out  1  in-order data beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH  payload
- out_tag  out  $clog2(NUM_TAGS)  tag of beat
- out_last  out  1  final beat of request
- err  out  1  one-cycle pulse on protocol violation (see Configuration)

## Operation
- Storage: NUM_TAGS×MAX_BEATS data RAM, indexed {tag, beat}. Per tag: busy bit, expected count, received count.
- Allocation: alloc_ptr wraps modulo NUM_TAGS. req_ready = !busy[alloc_ptr] and req_tag = alloc_ptr. On handshake, set busy, store req_beats, clear received count, and increment alloc_ptr.
- Capture: when cpl_valid is high, write cpl_data to RAM[{cpl_tag, cpl_beat}] and increment received[cpl_tag]. A tag is complete when received equals expected.
- Release: rel_ptr names the oldest busy tag. State machine: IDLE → (busy[rel_ptr] && complete) → STREAM, with beat counter 0..expected-1 read through a registered RAM read port. Then:
  - out_last is asserted with beat == expected-1.
  - On acceptance of the last beat, clear busy[rel_ptr], increment rel_ptr, and return to IDLE (or re-enter STREAM directly if the next tag is already complete).
- Full: all NUM_TAGS busy, so req_ready=0. Empty: rel_ptr == alloc_ptr with nothing busy, so out_valid=0.

## Timing
- Reset values: req_ready=1, out_valid=0, out_last=0, err=0, out_data/out_tag=0; all busy cleared, both pointers 0.
- req_tag is combinational from alloc_ptr; request handshake costs zero cycles.
- The final completion beat accepted in cycle N produces out_valid no earlier than N+2 and no later than N+2 if the output is idle.
- Subsequent beats of a STREAM issue back-to-back, one per cycle, while out_ready=1. With out_ready=0, out_valid/out_data/out_tag/out_last hold stable.
- A tag freed in cycle N shows req_ready=1 at N+1; there is no same-cycle free/realloc bypass.
- A completion and a release on different tags in the same cycle both proceed.
- Reset mid-operation: all state is discarded; any completion arriving afterwards targets a non-busy tag.

## Configuration
- ASE_PCIE_SS_CPL_CHECK_EN defined: err pulses and the offending beat is dropped (no RAM write, no count change) when any of the following occurs:
  - completion to a non-busy tag
  - cpl_beat ≥ expected
  - a beat arrives after the tag is complete
  - req_beats == 0 is accepted (that request is treated as 1 beat)
- Undefined: no checks; err tied to 0; every completion beat is written and counted unconditionally.

## Test plan
- Four 2-beat requests get tags 0,1,2,3. Completions arrive in order 3,1,0,2, one beat per cycle. Required output is tag order 0,1,2,3 with correct data, and out_last on each second beat.
- Single 1-beat request, completion in cycle 10 → out_valid in cycle 12, out_tag=0, out_last=1.
- Issue 64 requests, so req_ready=0. Drain tag 0 → req_ready=1 one cycle later, next req_tag=0 (wrap).
- out_ready held low 5 cycles mid-stream of an 8-beat tag → outputs stable, no beat lost or duplicated.
- CHECK_EN: completion to idle tag 5 → err=1 for exactly one cycle, no output. Without the macro, err stays 0.
- Reset asserted with 3 tags outstanding → next cycle req_ready=1, req_tag=0, out_valid=0.
